// File: rtl/mem_responder.sv
// mem_responder: word-addressed RAM behind the MAR/MDR bus.
// Services each Read/Write strobe edge after WAIT_CYCLES wait states.
//
// Ports:
//   Clock     in   rising-edge clock
//   clear     in   async active-low reset
//   Read      in   read strobe
//   Write     in   write strobe
//   address   in   word address (latched at accept)
//   data_in   in   write data (latched at accept)
//   Mdatain   out  read data, held until next completed read
//   mem_ready out  one-cycle pulse on access completion
//   busy      out  high while an accepted access is in flight
//   err       out  one-cycle pulse on illegal/dropped request
module mem_responder #(
  parameter int ADDR_W      = 9,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              Clock,
  input  logic              clear,
  input  logic              Read,
  input  logic              Write,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] Mdatain,
  output logic              mem_ready,
  output logic              busy,
  output logic              err
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W =
    (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT =
    CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  count;
  logic              req_q;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_data;
  logic              op_wr;

  logic [DATA_W-1:0] ram [DEPTH];

  logic req;
  logic new_req;

  assign req     = Read | Write;
  assign new_req = req & ~req_q;

  // RAM has no reset; a write only lands in
  // ACCESS, which reset always leaves.
  always_ff @(posedge Clock) begin
    if (state == S_ACCESS && op_wr)
      ram[lat_addr] <= lat_data;
  end

  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      state     <= S_IDLE;
      count     <= '0;
      req_q     <= 1'b0;
      lat_addr  <= '0;
      lat_data  <= '0;
      op_wr     <= 1'b0;
      Mdatain   <= '0;
      mem_ready <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      req_q     <= req;
      mem_ready <= 1'b0;
      err       <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (new_req) begin
            if (Read && Write) begin
              err <= 1'b1;
            end else begin
              lat_addr <= address;
              lat_data <= data_in;
              op_wr    <= Write;
              busy     <= 1'b1;
              if (WAIT_CYCLES == 0) begin
                state <= S_ACCESS;
              end else begin
                count <= CNT_INIT;
                state <= S_WAIT;
              end
            end
          end
        end
        S_WAIT: begin
          // A fresh edge while busy is dropped.
          err <= new_req;
          if (count == '0)
            state <= S_ACCESS;
          else
            count <= count - 1'b1;
        end
        S_ACCESS: begin
          err <= new_req;
          if (!op_wr)
            Mdatain <= ram[lat_addr];
          mem_ready <= 1'b1;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
